// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver_if
// Brief    : Digit load bus and multiplexed display outputs of seg_scan_driver
// Revision : 1.0
// ============================================================================
interface seg_scan_driver_if #(
  parameter int DIGITS = 6
);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
  logic [DIGITS-1:0]     seg_sel;
  logic [7:0]            seg_data;
  logic                  frame_done;

  modport master (
    output load, data_in, dp_in, blank_in,
    input  seg_sel, seg_data, frame_done
  );

  modport slave (
    input  load, data_in, dp_in, blank_in,
    output seg_sel, seg_data, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Time-multiplexed 7-segment scanner, double-buffered, with guard
// Revision : 1.0
// ============================================================================
module seg_scan_driver #(
  parameter int DIGITS         = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 16,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int LZ_SUPPRESS    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_driver_if.slave   bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  c_CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  c_GUARD   = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0]  c_IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] c_SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0]        c_SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic [DIGITS-1:0]   seg_sel_q, seg_sel_d;
  logic [7:0]          seg_data_q, seg_data_d;
  logic                frame_done_q, frame_done_d;

  logic                slot_wrap, frame_wrap, in_guard;
  logic [DIGITS-1:0]   lz_mask, sel_raw;
  logic [3:0]          cur_val;
  logic                cur_dp, cur_blank, cur_lz;
  logic [7:0]          seg_raw;

  function automatic logic [6:0] f_decode(input logic [3:0] v);
    case (v)
      4'h0: f_decode = 7'h3F;  4'h1: f_decode = 7'h06;
      4'h2: f_decode = 7'h5B;  4'h3: f_decode = 7'h4F;
      4'h4: f_decode = 7'h66;  4'h5: f_decode = 7'h6D;
      4'h6: f_decode = 7'h7D;  4'h7: f_decode = 7'h07;
      4'h8: f_decode = 7'h7F;  4'h9: f_decode = 7'h6F;
      4'hA: f_decode = 7'h77;  4'hB: f_decode = 7'h7C;
      4'hC: f_decode = 7'h39;  4'hD: f_decode = 7'h5E;
      4'hE: f_decode = 7'h79;  default: f_decode = 7'h71;
    endcase
  endfunction

  assign slot_wrap  = (div_cnt_q == c_CNT_MAX);
  assign frame_wrap = slot_wrap && (idx_q == c_IDX_MAX);
  assign in_guard   = (div_cnt_q < c_GUARD);

  // A digit is a leading zero when it and every more-significant digit are 0.
  for (genvar i = 0; i < DIGITS; i++) begin : g_lz
    if (i == 0) begin : g_lz_lsd
      assign lz_mask[i] = 1'b0;
    end else begin : g_lz_upper
      assign lz_mask[i] = (LZ_SUPPRESS != 0) && (act_data_q[4*DIGITS-1:4*i] == '0);
    end
  end

  always_comb begin
    div_cnt_d    = slot_wrap ? '0 : div_cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == c_IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    if (bus.load) begin
      pend_data_d  = bus.data_in;
      pend_dp_d    = bus.dp_in;
      pend_blank_d = bus.blank_in;
    end
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    // A load coinciding with the wrap must reach the display this frame.
    if (frame_wrap) begin
      act_data_d  = bus.load ? bus.data_in  : pend_data_q;
      act_dp_d    = bus.load ? bus.dp_in    : pend_dp_q;
      act_blank_d = bus.load ? bus.blank_in : pend_blank_q;
    end
    frame_done_d = frame_wrap;
  end

  always_comb begin
    cur_val   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    cur_lz    = 1'b0;
    sel_raw   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_val    = act_data_q[4*i +: 4];
        cur_dp     = act_dp_q[i];
        cur_blank  = act_blank_q[i];
        cur_lz     = lz_mask[i];
        sel_raw[i] = 1'b1;
      end
    end
    seg_raw = cur_blank ? 8'h00 : {cur_dp, (cur_lz ? 7'h00 : f_decode(cur_val))};
    if (in_guard) begin
      seg_raw = 8'h00;
      sel_raw = '0;
    end
    seg_sel_d  = sel_raw ^ c_SEL_OFF;
    seg_data_d = seg_raw ^ c_SEG_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '1;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      seg_sel_q    <= c_SEL_OFF;
      seg_data_q   <= c_SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      seg_sel_q    <= seg_sel_d;
      seg_data_q   <= seg_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg_sel    = seg_sel_q;
  assign bus.seg_data   = seg_data_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Directed self-checking bench for seg_scan_driver (4 digits, 8/2)
// Revision : 1.0
// ============================================================================
module tb_seg_scan_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   k     = 0;   // posedge count since the last reset release

  always #5 clk = ~clk;

  seg_scan_driver_if #(.DIGITS(4)) bus ();
  seg_scan_driver_if #(.DIGITS(4)) bus_lz ();

  seg_scan_driver #(
    .DIGITS(4), .SCAN_DIV(8), .GUARD(2),
    .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1), .LZ_SUPPRESS(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  seg_scan_driver #(
    .DIGITS(4), .SCAN_DIV(8), .GUARD(2),
    .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1), .LZ_SUPPRESS(1)
  ) dut_lz (
    .clk(clk), .rst_n(rst_n), .bus(bus_lz.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  function automatic logic [6:0] seg_tbl(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  // Expected select for the output visible after posedge kk.
  function automatic logic [3:0] exp_sel(input int kk);
    int p, s;
    logic [3:0] one;
    p = (kk - 1) % 8;
    s = ((kk - 1) / 8) % 4;
    one = 4'b0001 << s;
    return (p < 2) ? 4'hF : ~one;
  endfunction

  function automatic logic [7:0] exp_seg(input int kk, input logic [15:0] d,
                                         input logic [3:0] dp, input logic [3:0] bl,
                                         input bit lzen);
    int p, s;
    logic [7:0] raw;
    logic [15:0] upper;
    bit lz;
    p = (kk - 1) % 8;
    s = ((kk - 1) / 8) % 4;
    if (p < 2) return 8'hFF;
    upper = d >> (4 * s);
    lz = lzen && (s != 0) && (upper == 16'h0);
    if (bl[s]) raw = 8'h00;
    else       raw = {dp[s], (lz ? 7'h00 : seg_tbl(d[4*s +: 4]))};
    return ~raw;
  endfunction

  task automatic test_reset();
    bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.blank_in = '0;
    bus_lz.load = 1'b0; bus_lz.data_in = '0; bus_lz.dp_in = '0; bus_lz.blank_in = '0;
    rst_n = 1'b0;
    #12;
    total++;
    if (bus.seg_sel !== 4'hF) begin
      bad++; $display("FAIL rst_sel got=%h want=%h", bus.seg_sel, 4'hF);
    end
    total++;
    if (bus.seg_data !== 8'hFF) begin
      bad++; $display("FAIL rst_data got=%h want=%h", bus.seg_data, 8'hFF);
    end
    total++;
    if (bus.frame_done !== 1'b0) begin
      bad++; $display("FAIL rst_fd got=%b want=0", bus.frame_done);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    k = 0;
    for (int n = 0; n < 64; n++) begin
      tick();
      total++;
      if (bus.seg_sel !== exp_sel(k)) begin
        bad++; $display("FAIL idle_sel k=%0d got=%h want=%h", k, bus.seg_sel, exp_sel(k));
      end
      total++;
      if (bus.seg_data !== 8'hFF) begin
        bad++; $display("FAIL idle_data k=%0d got=%h want=ff", k, bus.seg_data);
      end
      total++;
      if (bus.frame_done !== (k % 32 == 0)) begin
        bad++; $display("FAIL idle_fd k=%0d got=%b want=%b", k, bus.frame_done, (k % 32 == 0));
      end
    end
  endtask

  // Load 1234 early in a frame; it appears only from the next frame onward.
  task automatic test_load_display();
    logic [7:0] e;
    bus.data_in = 16'h1234; bus.dp_in = 4'h0; bus.blank_in = 4'h0; bus.load = 1'b1;
    while (k < 128) begin
      tick();
      bus.load = 1'b0;
      e = (k <= 96) ? exp_seg(k, 16'h0, 4'h0, 4'hF, 0) : exp_seg(k, 16'h1234, 4'h0, 4'h0, 0);
      total++;
      if (bus.seg_sel !== exp_sel(k)) begin
        bad++; $display("FAIL scan_sel k=%0d got=%h want=%h", k, bus.seg_sel, exp_sel(k));
      end
      total++;
      if (bus.seg_data !== e) begin
        bad++; $display("FAIL scan_data k=%0d got=%h want=%h", k, bus.seg_data, e);
      end
    end
    // Spot values from the first displayed frame of 1234.
    total++;
    if (exp_seg(100, 16'h1234, 4'h0, 4'h0, 0) !== 8'h99 || exp_seg(125, 16'h1234, 4'h0, 4'h0, 0) !== 8'hF9 ||
        exp_sel(100) !== 4'b1110 || exp_sel(125) !== 4'b0111) begin
      bad++; $display("FAIL model_spot got=%h/%h want=99/f9", exp_seg(100, 16'h1234, 4'h0, 4'h0, 0),
                      exp_seg(125, 16'h1234, 4'h0, 4'h0, 0));
    end
  endtask

  // Mid-frame load of 5678 must not disturb the 1234 frame in progress.
  task automatic test_tear_free();
    logic [7:0] e;
    while (k < 191) begin
      if (k == 140) begin
        bus.data_in = 16'h5678; bus.load = 1'b1;
      end
      tick();
      bus.load = 1'b0;
      e = (k <= 160) ? exp_seg(k, 16'h1234, 4'h0, 4'h0, 0) : exp_seg(k, 16'h5678, 4'h0, 4'h0, 0);
      total++;
      if (bus.seg_data !== e) begin
        bad++; $display("FAIL tear_data k=%0d got=%h want=%h", k, bus.seg_data, e);
      end
      total++;
      if (bus.frame_done !== (k % 32 == 0)) begin
        bad++; $display("FAIL tear_fd k=%0d got=%b want=%b", k, bus.frame_done, (k % 32 == 0));
      end
    end
  endtask

  // Load in the wrap cycle itself goes straight to the display.
  task automatic test_back_to_back();
    logic [7:0] e;
    bus.data_in = 16'hCAFE; bus.dp_in = 4'b0010; bus.blank_in = 4'b1000; bus.load = 1'b1;
    while (k < 224) begin
      tick();
      bus.load = 1'b0;
      e = (k <= 192) ? exp_seg(k, 16'h5678, 4'h0, 4'h0, 0) : exp_seg(k, 16'hCAFE, 4'b0010, 4'b1000, 0);
      total++;
      if (bus.seg_data !== e) begin
        bad++; $display("FAIL bypass_data k=%0d got=%h want=%h", k, bus.seg_data, e);
      end
      total++;
      if (bus.seg_sel !== exp_sel(k)) begin
        bad++; $display("FAIL bypass_sel k=%0d got=%h want=%h", k, bus.seg_sel, exp_sel(k));
      end
    end
  endtask

  task automatic test_lz();
    logic [7:0] e;
    bus_lz.data_in = 16'h0050; bus_lz.dp_in = 4'b0100; bus_lz.blank_in = 4'h0; bus_lz.load = 1'b1;
    while (k < 288) begin
      tick();
      bus_lz.load = 1'b0;
      e = (k <= 256) ? 8'hFF : exp_seg(k, 16'h0050, 4'b0100, 4'h0, 1);
      if (k > 256 && (k - 1) % 8 >= 2) begin
        case (((k - 1) / 8) % 4)
          0: e = 8'hC0;
          1: e = 8'h92;
          2: e = 8'h7F;
          default: e = 8'hFF;
        endcase
      end
      total++;
      if (bus_lz.seg_data !== e) begin
        bad++; $display("FAIL lz_data k=%0d got=%h want=%h", k, bus_lz.seg_data, e);
      end
      total++;
      if (bus_lz.seg_sel !== exp_sel(k)) begin
        bad++; $display("FAIL lz_sel k=%0d got=%h want=%h", k, bus_lz.seg_sel, exp_sel(k));
      end
    end
  endtask

  task automatic test_reset_mid();
    while (k < 308) tick();
    total++;
    if (bus.seg_sel !== 4'b1011 || bus.seg_data !== 8'h88) begin
      bad++; $display("FAIL pre_rst got=%h/%h want=b/88", bus.seg_sel, bus.seg_data);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.seg_sel !== 4'hF) begin
      bad++; $display("FAIL mid_rst_sel got=%h want=f", bus.seg_sel);
    end
    total++;
    if (bus.seg_data !== 8'hFF) begin
      bad++; $display("FAIL mid_rst_data got=%h want=ff", bus.seg_data);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    k = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      total++;
      if (bus.seg_sel !== exp_sel(k)) begin
        bad++; $display("FAIL post_rst_sel k=%0d got=%h want=%h", k, bus.seg_sel, exp_sel(k));
      end
      total++;
      if (bus.seg_data !== 8'hFF) begin
        bad++; $display("FAIL post_rst_data k=%0d got=%h want=ff", k, bus.seg_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_display();
    test_tear_free();
    test_back_to_back();
    test_lz();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
